// File: rtl/rr_arb_mux.sv
// N:1 arbitrated mux (round-robin or fixed priority) into one registered valid/ready output stage.
// Latency 1 cycle; a held word that is not accepted blocks every grant until out_ready rises.
module rr_arb_mux #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int RR_MODE = 1,
  parameter int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  logic [NUM_CH-1:0] req;
  logic              load_ok;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  nxt_ptr;
  logic [DATA_W-1:0] ch_dat [NUM_CH];
  int                idx;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_dat[k] = in_data[k*DATA_W +: DATA_W];
  end

  assign req     = in_valid & ch_en;
  assign load_ok = !out_valid || out_ready;

  // Scan channels starting at the pointer (RR) or at 0 (fixed), wrapping at NUM_CH.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (RR_MODE != 0) ? int'(ptr) + i : i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (load_ok && !gnt_vld && req[SEL_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

  assign nxt_ptr  = (int'(gnt_idx) + 1 >= NUM_CH) ? '0 : gnt_idx + 1'b1;
  assign in_ready = (rst_n && gnt_vld) ? (NUM_CH'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (gnt_vld) begin
      out_valid <= 1'b1;
      out_data  <= ch_dat[gnt_idx];
      out_sel   <= gnt_idx;
      if (RR_MODE != 0) ptr <= nxt_ptr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Drives a round-robin and a fixed-priority instance with shared stimulus; a reference
// model queues expected words and a monitor pops them as each output is accepted.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  ch_en = 4'hF;
  logic [3:0]  in_valid = 4'h0;
  logic [31:0] in_data = 32'h0;
  logic        out_ready = 1'b0;
  logic [3:0]  rdy [2];
  logic        ov  [2];
  logic [7:0]  od  [2];
  logic [1:0]  os  [2];

  int checks = 0;
  int failures = 0;

  // Reference state: index 0 = round-robin instance, 1 = fixed-priority instance.
  int         m_ptr  [2];
  bit         m_ov   [2];
  logic [9:0] m_last [2];
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];

  always #5 clk = ~clk;

  rr_arb_mux #(.NUM_CH(4), .DATA_W(8), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]),
    .out_ready(out_ready)
  );

  rr_arb_mux #(.NUM_CH(4), .DATA_W(8), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input int m, input logic [3:0] r, input int ptr);
    int start;
    start = (m == 0) ? ptr : 0;
    for (int off = 0; off < 4; off++)
      if (r[(start + off) % 4]) return (start + off) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_ov[m] = 1'b0; m_last[m] = '0;
    end
    q0.delete(); q1.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic cycle(input logic [3:0] iv, input logic [3:0] en, input logic ordy,
                       input logic [31:0] dat);
    int w;
    logic [3:0] exp_rdy;
    @(negedge clk);
    rst_n = 1'b1; in_valid = iv; ch_en = en; out_ready = ordy; in_data = dat;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk(m == 0 ? "rr_out_valid" : "fp_out_valid", 32'(ov[m]), 32'(m_ov[m]));
      chk(m == 0 ? "rr_out_hold" : "fp_out_hold", 32'({os[m], od[m]}), 32'(m_last[m]));
      w = (m_ov[m] && !ordy) ? -1 : winner(m, iv & en, m_ptr[m]);
      exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk(m == 0 ? "rr_in_ready" : "fp_in_ready", 32'(rdy[m]), 32'(exp_rdy));
      if (w >= 0) begin
        m_last[m] = {2'(w), dat[w*8 +: 8]};
        if (m == 0) q0.push_back(m_last[m]); else q1.push_back(m_last[m]);
        m_ov[m] = 1'b1;
        if (m == 0) m_ptr[m] = (w + 1) % 4;
      end else if (m_ov[m] && ordy) begin
        m_ov[m] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    in_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("reset_out_valid", 32'(ov[m]), 32'd0);
      chk("reset_out_data", 32'(od[m]), 32'd0);
      chk("reset_out_sel", 32'(os[m]), 32'd0);
      chk("reset_in_ready", 32'(rdy[m]), 32'd0);
    end
    model_reset();
  endtask

  // Monitor: every accepted output word must match the oldest expected word.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (ov[0] && out_ready) begin
        if (q0.size() == 0) chk("rr_unexpected_word", 32'({os[0], od[0]}), 32'hFFFF);
        else chk("rr_word", 32'({os[0], od[0]}), 32'(q0.pop_front()));
      end
      if (ov[1] && out_ready) begin
        if (q1.size() == 0) chk("fp_unexpected_word", 32'({os[1], od[1]}), 32'hFFFF);
        else chk("fp_word", 32'({os[1], od[1]}), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    model_reset();
    #2;
    in_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("init_out_valid", 32'(ov[m]), 32'd0);
      chk("init_out_data", 32'(od[m]), 32'd0);
      chk("init_out_sel", 32'(os[m]), 32'd0);
      chk("init_in_ready", 32'(rdy[m]), 32'd0);
    end

    // Round-robin sweep 0,1,2,3,0,1, then stall with A1 held, then release.
    for (int i = 0; i < 6; i++) cycle(4'hF, 4'hF, 1'b1, 32'hA3A2A1A0);
    for (int i = 0; i < 3; i++) cycle(4'hF, 4'hF, 1'b0, 32'hA3A2A1A0);
    for (int i = 0; i < 3; i++) cycle(4'hF, 4'hF, 1'b1, 32'hA3A2A1A0);

    // Fixed priority with 1010, then 1000.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(4'b1010, 4'hF, 1'b1, 32'hD3D2D1D0);
    for (int i = 0; i < 2; i++) cycle(4'b1000, 4'hF, 1'b1, 32'hD3D2D1D0);

    // Mask and wrap: move pointer to 3, mask ch3, then confirm pointer = 1.
    do_reset();
    cycle(4'b0100, 4'hF, 1'b1, 32'h13121110);
    cycle(4'b1001, 4'b0111, 1'b1, 32'h23222120);
    cycle(4'hF, 4'hF, 1'b1, 32'h33323130);

    // Idle drain of a single word on ch2.
    do_reset();
    cycle(4'b0100, 4'hF, 1'b1, 32'h005C0000);
    for (int i = 0; i < 4; i++) cycle(4'b0000, 4'hF, 1'b1, 32'h00000000);

    // Randomized traffic with occasional mid-stream resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
            1'($urandom_range(0, 3) != 0), $urandom);
    end
    for (int i = 0; i < 3; i++) cycle(4'h0, 4'hF, 1'b1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N:1 registered channel multiplexer. It replaces the fixed 4:1 combinational select mux with an arbitrated, handshaked mux.
- N requesters present valid/data. The block selects one per cycle, using round-robin or fixed priority as configured.
- The selected word is registered into a single output stage with valid/ready flow control.
- It sits between multiple producer channels and one shared downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels (>=1).
- DATA_W, 8, data width per channel in bits.
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SEL_W, max(1,$clog2(NUM_CH)), width of the channel index. Derived; must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset. Assertion takes effect immediately; release is used synchronously to clk.
- ch_en  input  NUM_CH  per-channel enable mask. A channel with its bit at 0 is never granted.
- in_valid  input  NUM_CH  per-channel request, valid data present.
- in_data  input  NUM_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  one-hot (or zero) grant/accept per channel.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered selected data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_sel=0, rr pointer=0.
  - in_ready forced to all-zero while rst_n is low.
- Request vector: req = in_valid & ch_en.
- Load condition: load_ok = !out_valid | out_ready.
- Grant, combinational from current state:
  - When load_ok and req != 0, exactly one bit of in_ready is 1, at the winning index g. Otherwise in_ready = 0.
  - RR_MODE=1: g is the first set bit of req found searching upward from the pointer, wrapping from NUM_CH-1 to 0.
  - RR_MODE=0: g is the lowest set bit of req. The pointer is ignored and held at 0.
- Transfer: occurs on a clock edge where in_valid[g] & in_ready[g]. On that edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - RR_MODE=1 only: pointer <= (g+1) mod NUM_CH.
- Drain: on an edge with out_valid & out_ready and no transfer, out_valid <= 0. out_data and out_sel hold their last values.
- Stall: while out_valid & !out_ready, all in_ready are 0 and out_valid, out_data, out_sel are held stable.
- Simultaneous drain and load: the new word replaces the old in the same edge and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Latency: a word accepted at edge n appears on out_data after edge n and is visible in cycle n+1.
- Pointer: advances only on a transfer. Idle cycles and stalls leave it unchanged.
- Fairness (RR_MODE=1): with all channels requesting continuously and out_ready=1, grants cycle 0,1,..,NUM_CH-1,0,...
- Masked channel (ch_en[k]=0): in_ready[k]=0 regardless of in_valid[k]. Changing ch_en mid-stream only affects the next grant decision.
- NUM_CH=1:
  - SEL_W=1 and out_sel is always 0.
  - The block degenerates to a registered valid/ready stage.
- Producer obligations: producers hold in_valid and in_data stable until accepted. The block does not rely on this for correctness; it samples only at the transfer edge.
- Reset mid-operation: a held output word is discarded (out_valid=0 immediately). The pointer returns to 0 and no in_ready is asserted until reset is released.

Test Plan:
- Reset: rst_n=0 with all in_valid=1.
  - Required: out_valid=0, out_data=0, out_sel=0, in_ready=0000 immediately, not only after a clk edge.
- Round-robin sweep: RR_MODE=1, NUM_CH=4, DATA_W=8, all in_valid=1, in_data ch k=8'hA0+k, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0 with out_data A0,A1,A2,A3,A0, one per cycle, with out_valid=1 continuously.
- Backpressure: after out_data=A1, hold out_ready=0 for 3 cycles.
  - Required: in_ready=0000 and out_data=A1, out_sel=1 held stable for those cycles.
  - Required: on release, the next output is A2 (pointer unchanged by the stall).
- Fixed priority: RR_MODE=0, in_valid=1010, out_ready=1.
  - Required: ch1 is granted every cycle (out_sel=1). When in_valid goes to 1000, ch3 is granted on the next edge.
- Mask and wrap: RR_MODE=1, pointer=3, in_valid=1001, ch_en=0111.
  - Required: ch3 is skipped and ch0 is granted (out_sel=0), and the pointer becomes 1.
- Idle drain: a single request on ch2 (data 8'h5C), then in_valid=0000 with out_ready=1.
  - Required: out_valid is 1 for exactly one cycle with out_data=5C, then 0. out_data holds 5C while out_valid=0.
